// File: rtl/demux_1to3_buffered.sv
// Registered 1-to-3 stream demultiplexer: steers one word per cycle by address into one of
// three single-entry output buffers, each with its own valid/ready handshake; address 3 discards.
module demux_1to3_buffered #(
    parameter int dataSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [dataSize-1:0] in_data,
    input  logic [1:0]          in_addr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [dataSize-1:0] out0_data,
    output logic [dataSize-1:0] out1_data,
    output logic [dataSize-1:0] out2_data,
    output logic                out0_valid,
    output logic                out1_valid,
    output logic                out2_valid,
    input  logic                out0_ready,
    input  logic                out1_ready,
    input  logic                out2_ready,
    output logic [7:0]          drop_count
);

    logic [dataSize-1:0] data_q [0:2];
    logic [dataSize-1:0] data_d [0:2];
    logic [2:0]          valid_q, valid_d;
    logic [7:0]          drop_q, drop_d;
    logic [2:0]          ready_vec;
    logic                accept;

    assign ready_vec = {out2_ready, out1_ready, out0_ready};

    // A channel can take a new word if it is empty or is being drained this same edge.
    always_comb begin
        in_ready = 1'b1;
        case (in_addr)
            2'd0:    in_ready = !valid_q[0] || ready_vec[0];
            2'd1:    in_ready = !valid_q[1] || ready_vec[1];
            2'd2:    in_ready = !valid_q[2] || ready_vec[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        drop_d  = drop_q;
        for (int n = 0; n < 3; n++) begin
            data_d[n] = data_q[n];
            if (valid_q[n] && ready_vec[n]) begin
                valid_d[n] = 1'b0;
            end
            if (accept && (in_addr == 2'(n))) begin
                valid_d[n] = 1'b1;
                data_d[n]  = in_data;
            end
        end
        if (accept && (in_addr == 2'd3) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            drop_q  <= '0;
            for (int n = 0; n < 3; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
            for (int n = 0; n < 3; n++) begin
                data_q[n] <= data_d[n];
            end
        end
    end

    assign out0_data  = data_q[0];
    assign out1_data  = data_q[1];
    assign out2_data  = data_q[2];
    assign out0_valid = valid_q[0];
    assign out1_valid = valid_q[1];
    assign out2_valid = valid_q[2];
    assign drop_count = drop_q;

endmodule

// File: doc/demux_1to3_buffered.md
# demux_1to3_buffered

Registered 1-to-3 stream demultiplexer: accepts one data word per cycle on a valid/ready input and steers it, by a 2-bit address, into one of three output channels, each with a one-entry holding register and its own valid/ready handshake. It is the distribution counterpart of the datapath's 3:1 select muxes. It fans a single producer, such as a writeback or result bus, out to three consumers that may stall independently. Words sent to the unused address are discarded and counted.

## Interface
- dataSize, 32: width of the data word on the input and every output channel.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_data  in  dataSize  word offered by the producer.
- in_addr  in  2  destination channel: 0, 1 or 2; 3 = discard.
- in_valid  in  1  producer has a word on in_data/in_addr.
- in_ready  out  1  block can take the offered word this cycle.
- out0_data / out1_data / out2_data  out  dataSize  held word for channel 0/1/2.
- out0_valid / out1_valid / out2_valid  out  1  channel holds an undelivered word.
- out0_ready / out1_ready / out2_ready  in  1  consumer takes the word this cycle.
- drop_count  out  8  number of words discarded via addr 3; saturates at 255.

## Operation
- Input transfer ("accept") occurs on a rising edge when in_valid && in_ready.
- Output transfer ("drain" of channel N) occurs on a rising edge when outN_valid && outN_ready.
- in_ready is combinational:
  - in_addr == 3: in_ready = 1.
  - in_addr == N: in_ready = !outN_valid || outN_ready.
  - in_ready depends only on in_addr, outN_valid and outN_ready, never on in_valid.
- Accept to channel N: outN_data <= in_data; outN_valid <= 1.
- Drain of channel N with no accept to N in the same cycle: outN_valid <= 0. outN_data keeps its last value, which is don't-care while invalid.
- Drain and accept to the same channel in the same cycle: outN_valid stays 1 and outN_data takes the new word, giving full throughput of one word per cycle per channel.
- Accept with in_addr == 3: the word is discarded and drop_count increments by 1 unless it is already 255. No output state changes.
- Channels are independent. A stalled channel blocks the input only while in_addr points to it; no other channel is affected.
- Only one channel is loaded per cycle. Any number of channels may drain in the same cycle.
- The block never reorders words within a channel and never duplicates or loses a word sent to addr 0–2.

## Timing
- Reset (reset high at an edge): out0/1/2_valid = 0, out0/1/2_data = 0, drop_count = 0. This takes priority over any simultaneous accept or drain, and a held word is lost.
- While reset is high, in_ready still follows the combinational rule above. Because all valids are 0 after the first reset edge, in_ready reads 1, but no accept takes effect while reset is asserted.
- Latency: a word accepted at edge k is visible on outN_data with outN_valid = 1 immediately after edge k. An out ready at edge k+1 drains it.
- Stability: while outN_valid && !outN_ready, outN_data and outN_valid hold unchanged across edges.
- in_valid/in_data/in_addr are not required to be stable while in_ready = 0. A word is taken only at an accept edge.
- drop_count saturates: at 255, further discards leave it at 255 with no wrap.
- Combinational path: outN_ready -> in_ready, one gate level plus the in_addr decode. There is no path from in_valid to any output.

## Test plan
- Reset then idle: assert reset for 2 cycles while driving in_valid = 1, in_addr = 0, in_data = 0xDEADBEEF. Required: all valids 0, all data 0, drop_count 0, and no word appears after reset releases until the next accept.
- Routing: send 0x11111111 to addr 0, 0x22222222 to addr 1 and 0x33333333 to addr 2 on consecutive cycles, with all out ready = 0. Required: each outN_valid rises one cycle after its accept with the matching data. A 4th word to addr 1 sees in_ready = 0, while a word to addr 3 sees in_ready = 1 and raises drop_count to 1.
- Backpressure and hold: load 0xA5A5A5A5 into channel 2 and keep out2_ready = 0 for 5 cycles. Required: out2_data/out2_valid stable throughout and in_ready = 0 whenever in_addr = 2. Raising out2_ready drains the word in that cycle.
- Full throughput: stream 0x1–0x10 to addr 0 on 16 consecutive cycles with out0_ready = 1 constantly. Required: in_ready stays 1 and out0 delivers 0x1..0x10 in order, one per cycle.
- Drop saturation: send 300 words with in_addr = 3. Required: drop_count = 255 at the end and no out valid ever rises.
- Reset mid-operation: with channels 0 and 1 valid and stalled, assert reset for one cycle coincident with an accept to channel 2. Required: all valids 0 after that edge, channel 2 not loaded, and drop_count 0.
